mm_stage_sequencer: RTL and testbench

Top-level control FSM for the `mm` GEMM kernel. It launches the kernel's pipelined sub-functions (load/compute loop nest, accumulate loop, write-back loop) strictly in order, and can run each stage a programmable number of times. It speaks `ap_ctrl_hs` upward to the testbench/host and to every child stage. It also keeps per-stage and total cycle counters, so the simulation monitors can cross-check their CSV latency figures against the hardware.

---
 rtl/mm_stage_sequencer_if.sv | 28 ++
 rtl/mm_stage_sequencer.sv | 78 +++++++
 tb/tb_mm_stage_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mm_stage_sequencer_if.sv
// mm_stage_sequencer_if: ap_ctrl_hs host/child handshake and status bundle of the stage sequencer
interface mm_stage_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int REP_W = 16,
  parameter int CNT_W = 32
);
  localparam int IW = $clog2(NUM_STAGES + 1);
  logic ap_start;
  logic ap_done;
  logic ap_ready;
  logic ap_idle;
  logic [NUM_STAGES*REP_W-1:0] rep_count;
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_done;
  logic [IW-1:0] cur_stage;
  logic [CNT_W-1:0] total_cycles;
  logic [NUM_STAGES*CNT_W-1:0] stage_cycles;
  logic err_spurious_done;
  modport master (
    output ap_start, rep_count, stage_ready, stage_done,
    input ap_done, ap_ready, ap_idle, stage_start, cur_stage, total_cycles, stage_cycles, err_spurious_done
  );
  modport slave (
    input ap_start, rep_count, stage_ready, stage_done,
    output ap_done, ap_ready, ap_idle, stage_start, cur_stage, total_cycles, stage_cycles, err_spurious_done
  );
endinterface

// File: rtl/mm_stage_sequencer.sv
// mm_stage_sequencer: launches the mm kernel child stages in order with per-stage repeats and cycle counters
module mm_stage_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int REP_W = 16,
  parameter int CNT_W = 32
) (
  input logic ap_clk,
  input logic ap_rst_n,
  mm_stage_sequencer_if.slave bus
);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [IW-1:0] IDX_END = IW'(NUM_STAGES);
  typedef enum logic [2:0] {IDLE, SEL, RUN, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [IW-1:0] idx;
  logic [REP_W-1:0] rem [NUM_STAGES];
  logic [CNT_W-1:0] sc [NUM_STAGES];
  logic [CNT_W-1:0] total;
  logic [REP_W-1:0] cur_rem;
  logic [NUM_STAGES-1:0] sel, ok;
  logic err, go, rdy, dn, cpl, last, busy, skip;
  always_comb begin
    cur_rem = '0;
    for (int s = 0; s < NUM_STAGES; s++) if (idx == IW'(s)) cur_rem = rem[s];
    go = state == IDLE && bus.ap_start;
    sel = NUM_STAGES'(1) << idx;
    rdy = |(bus.stage_ready & sel);
    dn = |(bus.stage_done & sel);
    busy = state == RUN || state == WAIT;
    cpl = (state == RUN && rdy && dn) || (state == WAIT && dn);
    last = cur_rem == REP_W'(1);
    skip = state == SEL && idx != IDX_END && cur_rem == '0;
    // the only done pulse we accept is from the active child after it has taken its start
    ok = ((state == RUN && rdy) || state == WAIT) ? sel : '0;
    nxt = state;
    unique case (state)
      IDLE: nxt = bus.ap_start ? SEL : IDLE;
      SEL: nxt = idx == IDX_END ? DONE : cur_rem == '0 ? SEL : RUN;
      RUN: nxt = cpl ? (last ? SEL : RUN) : rdy ? WAIT : RUN;
      WAIT: nxt = cpl ? (last ? SEL : RUN) : WAIT;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
      idx <= '0;
      total <= '0;
      err <= 1'b0;
      for (int s = 0; s < NUM_STAGES; s++) begin
        rem[s] <= '0;
        sc[s] <= '0;
      end
    end else begin
      state <= nxt;
      err <= !go && (err || |(bus.stage_done & ~ok));
      total <= go ? '0 : (state != IDLE && ~&total) ? total + CNT_W'(1) : total;
      if (go) idx <= '0;
      else if (skip || (cpl && last)) idx <= idx + IW'(1);
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (go) rem[s] <= bus.rep_count[s*REP_W +: REP_W];
        else if (cpl && idx == IW'(s)) rem[s] <= rem[s] - REP_W'(1);
        if (go) sc[s] <= '0;
        else if (busy && idx == IW'(s) && ~&sc[s]) sc[s] <= sc[s] + CNT_W'(1);
      end
    end
  end
  assign bus.ap_idle = state == IDLE;
  assign bus.ap_done = state == DONE;
  assign bus.ap_ready = state == DONE;
  assign bus.stage_start = state == RUN ? sel : '0;
  assign bus.cur_stage = idx;
  assign bus.total_cycles = total;
  assign bus.err_spurious_done = err;
  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_sc
    assign bus.stage_cycles[g*CNT_W +: CNT_W] = sc[g];
  end
endmodule

// File: tb/tb_mm_stage_sequencer.sv
// tb_mm_stage_sequencer: scoreboard bench with behavioural ap_ctrl_hs children for the stage sequencer
module tb_mm_stage_sequencer;
  localparam int NS = 3;
  localparam int RW = 16;
  localparam int CW = 32;
  typedef struct packed {
    logic [31:0] total;
    logic [NS*32-1:0] sc;
    logic err;
  } exp_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;
  mm_stage_sequencer_if #(.NUM_STAGES(NS), .REP_W(RW), .CNT_W(CW)) bus ();
  mm_stage_sequencer #(.NUM_STAGES(NS), .REP_W(RW), .CNT_W(CW)) dut (
    .ap_clk(ap_clk),
    .ap_rst_n(ap_rst_n),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int rd[NS];
  int dd[NS];
  int k[NS];
  bit cbusy[NS];
  logic [NS-1:0] c_rdy = '0;
  logic [NS-1:0] c_dn = '0;
  logic [NS-1:0] inj = '0;
  assign bus.stage_ready = c_rdy;
  assign bus.stage_done = c_dn | inj;
  int cyc = 0;
  int start_cyc = 0;
  int lat = 0;
  int nstarts = 0;
  int launches = 0;
  int last_idx = 0;
  bit pend = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input int r0, input int r1, input int r2, input bit err);
    int reps[NS];
    exp_t e;
    reps = '{r0, r1, r2};
    e.total = 32'(NS + 2);
    e.sc = '0;
    for (int s = 0; s < NS; s++) begin
      e.sc[s*32 +: 32] = 32'(reps[s] * (rd[s] + dd[s] + 1));
      e.total += e.sc[s*32 +: 32];
    end
    e.err = err;
    return e;
  endfunction
  // child k counts cycles from its launch: ready at rd, done at rd+dd
  initial forever begin
    @(negedge ap_clk);
    for (int s = 0; s < NS; s++) begin
      if (!ap_rst_n) cbusy[s] = 0;
      else if (bus.stage_start[s] && !cbusy[s]) begin
        cbusy[s] = 1;
        k[s] = 0;
      end
      c_rdy[s] = cbusy[s] && k[s] == rd[s];
      c_dn[s] = cbusy[s] && k[s] == rd[s] + dd[s];
    end
    @(posedge ap_clk);
    for (int s = 0; s < NS; s++) if (cbusy[s]) begin
      if (c_dn[s]) cbusy[s] = 0;
      k[s]++;
    end
  end
  initial forever begin
    @(posedge ap_clk);
    cyc++;
  end
  initial forever begin
    exp_t e;
    @(negedge ap_clk);
    #1;
    if (!ap_rst_n) pend = 0;
    else begin
      if (pend) begin
        pend = 0;
        check("idle_after_done", bus.ap_idle, 1);
        if (sb.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          check("latency", lat, e.total - 1);
          check("total_cycles", bus.total_cycles, e.total);
          for (int s = 0; s < NS; s++)
            check($sformatf("stage_cycles%0d", s), bus.stage_cycles[s*CW +: CW], e.sc[s*32 +: 32]);
          check("err_spurious_done", bus.err_spurious_done, e.err);
        end
      end
      if (bus.ap_start && bus.ap_idle) begin
        start_cyc = cyc + 1;
        last_idx = 0;
        nstarts++;
      end
      if (bus.stage_start != '0) begin
        launches++;
        check("onehot", $countones(bus.stage_start), 1);
        check("start_vs_cur", bus.stage_start, 1 << bus.cur_stage);
        check("order", bus.cur_stage >= last_idx, 1);
        last_idx = bus.cur_stage;
      end
      if (bus.ap_done) begin
        lat = cyc - start_cyc;
        check("ap_ready", bus.ap_ready, 1);
        check("idle_in_done", bus.ap_idle, 0);
        pend = 1;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic set_child(input int s, input int r, input int d);
    rd[s] = r;
    dd[s] = d;
  endtask
  task automatic start_run(input int r0, input int r1, input int r2, input bit err);
    bus.rep_count = {RW'(r2), RW'(r1), RW'(r0)};
    sb.push_back(model(r0, r1, r2, err));
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 3000 && (sb.size() != 0 || pend); i++) @(negedge ap_clk);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge ap_clk);
  endtask
  initial begin
    int base;
    bus.ap_start = 1'b0;
    bus.rep_count = '0;
    for (int s = 0; s < NS; s++) set_child(s, 1, 10);
    repeat (3) @(negedge ap_clk);
    #1;
    check("rst_idle", bus.ap_idle, 1);
    check("rst_done", bus.ap_done, 0);
    check("rst_ready", bus.ap_ready, 0);
    check("rst_stage_start", bus.stage_start, 0);
    check("rst_cur_stage", bus.cur_stage, 0);
    check("rst_total", bus.total_cycles, 0);
    check("rst_stage_cycles", bus.stage_cycles, 0);
    check("rst_err", bus.err_spurious_done, 0);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    base = launches;
    start_run(0, 0, 0, 0);
    wait_idle();
    check("zero_no_launch", launches - base, 0);
    start_run(1, 1, 1, 0);
    wait_idle();
    set_child(1, 0, 0);
    base = launches;
    start_run(0, 3, 0, 0);
    wait_idle();
    check("rep_launch_cycles", launches - base, 3);
    set_child(0, 1, 10);
    set_child(1, 2, 1);
    set_child(2, 0, 3);
    start_run(1, 1, 1, 1);
    repeat (5) @(negedge ap_clk);
    check("inj_in_wait0", bus.cur_stage, 0);
    inj = 3'b100;
    @(negedge ap_clk);
    inj = '0;
    #1;
    check("err_sticky", bus.err_spurious_done, 1);
    wait_idle();
    start_run(1, 0, 1, 0);
    wait_idle();
    set_child(0, 0, 2);
    set_child(2, 2, 0);
    bus.rep_count = {RW'(2), RW'(0), RW'(1)};
    sb.push_back(model(1, 0, 2, 0));
    sb.push_back(model(1, 0, 2, 0));
    base = nstarts;
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    for (int i = 0; i < 500 && nstarts < base + 2; i++) @(negedge ap_clk);
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    check("held_two_starts", nstarts - base, 2);
    wait_idle();
    set_child(0, 1, 3);
    base = nstarts;
    start_run(2, 0, 0, 0);
    @(negedge ap_clk);
    bus.ap_start = 1'b1;
    @(negedge ap_clk);
    bus.ap_start = 1'b0;
    wait_idle();
    repeat (10) @(negedge ap_clk);
    check("run_pulse_ignored", nstarts - base, 1);
    check("idle_after_pulse", bus.ap_idle, 1);
    set_child(0, 0, 0);
    set_child(1, 1, 20);
    start_run(1, 1, 0, 0);
    repeat (8) @(negedge ap_clk);
    check("pre_rst_stage", bus.cur_stage, 1);
    check("pre_rst_wait", bus.stage_start, 0);
    #2;
    ap_rst_n = 1'b0;
    #1;
    check("async_stage_start", bus.stage_start, 0);
    check("async_idle", bus.ap_idle, 1);
    sb.delete();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    #1;
    check("post_rst_total", bus.total_cycles, 0);
    check("post_rst_stage_cycles", bus.stage_cycles, 0);
    check("post_rst_cur_stage", bus.cur_stage, 0);
    check("post_rst_idle", bus.ap_idle, 1);
    set_child(1, 0, 0);
    start_run(0, 2, 1, 0);
    wait_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
